cheshire_chip_sys_ctrl: RTL

- Chip-level system controller directly upstream of the Cheshire chip top.
- Generates the SoC's active-low reset, the latched boot-mode and test-mode straps, and the RTC clock from the single system clock.
- Samples asynchronous strap pads safely and holds the SoC in reset until the straps are stable.
- Accepts a software/board reset request that re-resets the SoC without re-sampling the straps.

---
 rtl/cheshire_chip_pkg.sv | 21 ++
 rtl/cheshire_chip_rtc_div.sv | 28 ++
 rtl/cheshire_chip_sys_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cheshire_chip_pkg.sv
// Shared types and default constants for the Cheshire chip-level system controller.
package cheshire_chip_pkg;

  typedef enum logic [1:0] {
    FILL,
    STABLE,
    HOLD,
    RUN
  } sys_ctrl_state_e;

  typedef struct packed {
    logic       test_mode;
    logic [1:0] boot_mode;
  } chip_strap_t;

  localparam int unsigned DefStrapStableCycles = 16;
  localparam int unsigned DefRstHoldCycles     = 64;
  localparam int unsigned DefRtcHalfPeriod     = 1526;
  localparam int unsigned DefNumSyncStages     = 2;

endpackage

// File: rtl/cheshire_chip_rtc_div.sv
// Free-running divider producing the RTC square wave from the system clock.
module cheshire_chip_rtc_div #(
  parameter int unsigned HalfPeriod = 1526
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rtc_o
);

  localparam int unsigned CntW = $clog2(HalfPeriod + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(HalfPeriod - 1);

  logic [CntW-1:0] cnt_q;

  // Count 0..HalfPeriod-1 and toggle the output on every wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rtc_o <= 1'b0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      rtc_o <= ~rtc_o;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cheshire_chip_sys_ctrl.sv
// Chip-level system controller: strap sampling, SoC reset sequencing and RTC generation.
module cheshire_chip_sys_ctrl
  import cheshire_chip_pkg::*;
#(
  parameter int unsigned StrapStableCycles = DefStrapStableCycles,
  parameter int unsigned RstHoldCycles     = DefRstHoldCycles,
  parameter int unsigned RtcHalfPeriod     = DefRtcHalfPeriod,
  parameter int unsigned NumSyncStages     = DefNumSyncStages
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] boot_mode_pad_i,
  input  logic       test_mode_pad_i,
  input  logic       sw_rst_req_i,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       test_mode_o,
  output logic       rtc_o,
  output logic       ready_o
);

  localparam int unsigned FillW   = $clog2(NumSyncStages + 1);
  localparam int unsigned StableW = $clog2(StrapStableCycles + 1);
  localparam int unsigned HoldW   = $clog2(RstHoldCycles + 1);

  // FILL runs one edge past the chain depth so the first value loaded into
  // strap_prev is already the real pad value, not a flushed zero.
  localparam logic [FillW-1:0]   FillLast   = FillW'(NumSyncStages);
  localparam logic [StableW-1:0] StableLast = StableW'(StrapStableCycles - 1);
  localparam logic [HoldW-1:0]   HoldLast   = HoldW'(RstHoldCycles - 1);

  chip_strap_t     sync_q [NumSyncStages];
  chip_strap_t     strap_s;
  chip_strap_t     strap_prev_q, strap_prev_d;
  chip_strap_t     strap_q, strap_d;
  sys_ctrl_state_e state_q, state_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [StableW-1:0] stable_q, stable_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               soc_rst_nq;
  logic               ready_q;

  // Multi-stage synchronizer for the asynchronous strap pads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumSyncStages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= chip_strap_t'({test_mode_pad_i, boot_mode_pad_i});
      for (int unsigned i = 1; i < NumSyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign strap_s = sync_q[NumSyncStages-1];

  // State, counters, latched straps and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FILL;
      fill_q       <= '0;
      stable_q     <= '0;
      hold_q       <= '0;
      strap_prev_q <= '0;
      strap_q      <= '0;
      soc_rst_nq   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      stable_q     <= stable_d;
      hold_q       <= hold_d;
      strap_prev_q <= strap_prev_d;
      strap_q      <= strap_d;
      soc_rst_nq   <= (state_d == RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  // Next-state logic: flush, wait for stable straps, hold reset, run.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    stable_d     = stable_q;
    hold_d       = hold_q;
    strap_prev_d = strap_prev_q;
    strap_d      = strap_q;
    unique case (state_q)
      FILL: begin
        if (fill_q == FillLast) begin
          state_d      = STABLE;
          strap_prev_d = strap_s;
          stable_d     = '0;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      STABLE: begin
        strap_prev_d = strap_s;
        if (strap_s == strap_prev_q) begin
          if (stable_q == StableLast) begin
            strap_d = strap_s;
            hold_d  = '0;
            state_d = HOLD;
          end else if (stable_q < StableLast) begin
            stable_d = stable_q + 1'b1;
          end
        end else begin
          stable_d = '0;
        end
      end
      HOLD: begin
        if (sw_rst_req_i) begin
          hold_d = '0;
        end else if (hold_q == HoldLast) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (sw_rst_req_i) begin
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      default: state_d = FILL;
    endcase
  end

  cheshire_chip_rtc_div #(
    .HalfPeriod(RtcHalfPeriod)
  ) i_rtc_div (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rtc_o(rtc_o)
  );

  assign soc_rst_no  = soc_rst_nq;
  assign ready_o     = ready_q;
  assign boot_mode_o = strap_q.boot_mode;
  assign test_mode_o = strap_q.test_mode;

  a_min_stable: assert property (@(posedge clk_i) StrapStableCycles >= 1);
  a_min_hold:   assert property (@(posedge clk_i) RstHoldCycles >= 1);
  a_min_rtc:    assert property (@(posedge clk_i) RtcHalfPeriod >= 1);
  a_min_sync:   assert property (@(posedge clk_i) NumSyncStages >= 2);
  a_rst_run:    assert property (@(posedge clk_i) soc_rst_no |-> state_q == RUN);
  a_boot_hold:  assert property (@(posedge clk_i)
                  (ready_o && !rst_i) |=> boot_mode_o == $past(boot_mode_o));

endmodule
